// File: rtl/cpu_icache_pkg.sv
// Shared types for the direct-mapped instruction cache: FSM states, line layout
// and tag-width helper.
package cpu_icache_pkg;

  typedef enum logic [1:0] {
    FLUSH  = 2'd0,
    IDLE   = 2'd1,
    LOOKUP = 2'd2,
    FILL   = 2'd3
  } state_t;

  // Widest tag over the legal SIZE range (SIZE=4); narrower tags are zero-extended.
  localparam int TAG_W_MAX = 26;

  function automatic int tag_w(input int size);
    return 30 - size;
  endfunction

  typedef struct packed {
    logic                 valid;
    logic [TAG_W_MAX-1:0] tag;
    logic [31:0]          data;
  } line_t;

endpackage

// File: rtl/cpu_icache_dm_ram.sv
// Simple dual-port line store: one write port, one read port with a
// registered (1-cycle) read. Contents are initialised by the FLUSH sweep.
module cpu_icache_dm_ram #(
  parameter int WIDTH      = 59,
  parameter int DEPTH_LOG2 = 8
) (
  input  logic                  i_clock,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] waddr,
  input  logic [WIDTH-1:0]      wdata,
  input  logic                  re,
  input  logic [DEPTH_LOG2-1:0] raddr,
  output logic [WIDTH-1:0]      rdata
);

  logic [WIDTH-1:0] mem [2**DEPTH_LOG2];

  always_ff @(posedge i_clock) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/cpu_icache_dm.sv
// Direct-mapped instruction cache between the fetch stage and the instruction
// bus, with hit/miss counters, flush command and post-reset invalidate sweep.
module cpu_icache_dm
  import cpu_icache_pkg::*;
#(
  parameter int SIZE = 8
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic [31:0] i_input_pc,
  output logic [31:0] o_rdata,
  output logic        o_ready,
  input  logic        i_stall,
  input  logic        i_flush,
  output logic        o_flush_busy,
  output logic        o_bus_request,
  input  logic        i_bus_ready,
  output logic [31:0] o_bus_address,
  input  logic [31:0] i_bus_rdata,
  output logic [31:0] o_hit,
  output logic [31:0] o_miss
);

  localparam int TAG_W = tag_w(SIZE);
  localparam logic [SIZE-1:0] LAST_IDX = {SIZE{1'b1}};

  state_t            state_reg, state_next;
  logic [SIZE-1:0]   flush_idx_reg, flush_idx_next;
  logic              flush_pending_reg, flush_pending_next;
  logic [31:0]       hit_reg, hit_next;
  logic [31:0]       miss_reg, miss_next;

  logic [SIZE-1:0]      pc_idx;
  logic [TAG_W_MAX-1:0] pc_tag;
  line_t                rd_line, wr_line;
  logic                 ram_we, ram_re;
  logic [SIZE-1:0]      ram_waddr;
  logic                 lookup_hit, flush_req;
  logic                 unused_pc_bits;

  assign pc_idx         = i_input_pc[SIZE+1:2];
  assign pc_tag         = TAG_W_MAX'(i_input_pc[31:SIZE+2]);
  assign unused_pc_bits = ^i_input_pc[1:0];
  assign lookup_hit     = rd_line.valid && (rd_line.tag == pc_tag);
  assign flush_req      = i_flush || flush_pending_reg;

  assign o_bus_address = {i_input_pc[31:2], 2'b00};
  assign o_flush_busy  = (state_reg == FLUSH);
  assign o_hit         = hit_reg;
  assign o_miss        = miss_reg;

  cpu_icache_dm_ram #(
    .WIDTH      ($bits(line_t)),
    .DEPTH_LOG2 (SIZE)
  ) u_ram (
    .i_clock (i_clock),
    .we      (ram_we),
    .waddr   (ram_waddr),
    .wdata   (wr_line),
    .re      (ram_re),
    .raddr   (pc_idx),
    .rdata   (rd_line)
  );

  always_comb begin
    state_next         = state_reg;
    flush_idx_next     = flush_idx_reg;
    flush_pending_next = flush_pending_reg | i_flush;
    hit_next           = hit_reg;
    miss_next          = miss_reg;
    ram_we             = 1'b0;
    ram_re             = 1'b0;
    ram_waddr          = pc_idx;
    wr_line            = '0;
    o_ready            = 1'b0;
    o_rdata            = '0;
    o_bus_request      = 1'b0;

    case (state_reg)
      FLUSH: begin
        ram_we         = 1'b1;
        ram_waddr      = flush_idx_reg;
        flush_idx_next = flush_idx_reg + 1'b1;
        if (i_flush) begin
          flush_idx_next = '0;
        end else if (flush_idx_reg == LAST_IDX) begin
          state_next = IDLE;
        end
      end
      IDLE: begin
        if (!i_stall) begin
          ram_re     = 1'b1;
          state_next = LOOKUP;
        end else if (flush_req) begin
          state_next = FLUSH;
        end
      end
      LOOKUP: begin
        if (lookup_hit) begin
          o_ready    = 1'b1;
          o_rdata    = rd_line.data;
          hit_next   = hit_reg + 32'd1;
          state_next = flush_req ? FLUSH : IDLE;
        end else begin
          o_bus_request = 1'b1;
          miss_next     = miss_reg + 32'd1;
          state_next    = FILL;
        end
      end
      FILL: begin
        o_bus_request = 1'b1;
        if (i_bus_ready) begin
          ram_we     = 1'b1;
          wr_line    = '{valid: 1'b1, tag: pc_tag, data: i_bus_rdata};
          o_ready    = 1'b1;
          o_rdata    = i_bus_rdata;
          state_next = flush_req ? FLUSH : IDLE;
        end
      end
      default: state_next = FLUSH;
    endcase

    // Every entry into the sweep starts from line 0 and consumes any pending request.
    if (state_next == FLUSH) begin
      flush_pending_next = 1'b0;
      if (state_reg != FLUSH) flush_idx_next = '0;
    end
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_reg         <= FLUSH;
      flush_idx_reg     <= '0;
      flush_pending_reg <= 1'b0;
      hit_reg           <= '0;
      miss_reg          <= '0;
    end else begin
      state_reg         <= state_next;
      flush_idx_reg     <= flush_idx_next;
      flush_pending_reg <= flush_pending_next;
      hit_reg           <= hit_next;
      miss_reg          <= miss_next;
    end
  end

endmodule

// File: tb/tb_cpu_icache_dm.sv
// Self-checking bench for cpu_icache_dm: table of fetches with a data
// scoreboard, plus hand-written reset, stall, flush and reset-mid-fill sequences.
module tb_cpu_icache_dm;

  logic        i_clock;
  logic        i_reset;
  logic [31:0] i_input_pc;
  logic [31:0] o_rdata;
  logic        o_ready;
  logic        i_stall;
  logic        i_flush;
  logic        o_flush_busy;
  logic        o_bus_request;
  logic        i_bus_ready;
  logic [31:0] o_bus_address;
  logic [31:0] i_bus_rdata;
  logic [31:0] o_hit;
  logic [31:0] o_miss;

  cpu_icache_dm #(.SIZE(8)) dut (
    .i_clock       (i_clock),
    .i_reset       (i_reset),
    .i_input_pc    (i_input_pc),
    .o_rdata       (o_rdata),
    .o_ready       (o_ready),
    .i_stall       (i_stall),
    .i_flush       (i_flush),
    .o_flush_busy  (o_flush_busy),
    .o_bus_request (o_bus_request),
    .i_bus_ready   (i_bus_ready),
    .o_bus_address (o_bus_address),
    .i_bus_rdata   (i_bus_rdata),
    .o_hit         (o_hit),
    .o_miss        (o_miss)
  );

  initial i_clock = 1'b0;
  always #5 i_clock = ~i_clock;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] bus_data;
    int          lat;
    bit          exp_hit;
    logic [31:0] exp_rdata;
    logic [31:0] exp_hits;
    logic [31:0] exp_misses;
  } vec_t;

  vec_t        vecs[15];
  logic [31:0] exp_q[$];
  int          n_cmp  = 0;
  int          n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
    end
  endtask

  // One fetch: drive pc, release stall for one acceptance cycle, answer the bus
  // once the request has been up for lat cycles, optionally pulse i_flush.
  task automatic do_fetch(input logic [31:0] pc, input logic [31:0] bus_data, input int lat,
                          input bit exp_hit, input logic [31:0] exp_rdata, input int flush_at);
    int          cycles = 0;
    int          req_cycles = 0;
    bit          done = 0;
    bit          saw_req = 0;
    logic [31:0] got = '0;
    logic [31:0] want;
    @(negedge i_clock);
    i_input_pc = pc;
    i_stall    = 1'b0;
    exp_q.push_back(exp_rdata);
    @(posedge i_clock);
    #1 i_stall = 1'b1;
    while (!done && cycles < 40) begin
      @(negedge i_clock);
      cycles++;
      i_flush = 1'b0;
      if (cycles == 1) check("bus_address", o_bus_address, {pc[31:2], 2'b00});
      if (o_bus_request) begin
        saw_req = 1'b1;
        req_cycles++;
        if (req_cycles == flush_at) i_flush = 1'b1;
        if (req_cycles > lat) begin
          i_bus_ready = 1'b1;
          i_bus_rdata = bus_data;
        end
      end
      #1;
      if (o_ready) begin
        done = 1'b1;
        got  = o_rdata;
        if (exp_q.size() == 0) begin
          check("unexpected_ready", 32'd1, 32'd0);
        end else begin
          want = exp_q.pop_front();
          check("rdata", got, want);
        end
      end
    end
    @(posedge i_clock);
    #1;
    i_bus_ready = 1'b0;
    i_bus_rdata = '0;
    i_flush     = 1'b0;
    if (!done) begin
      check("fetch_timeout", 32'd1, 32'd0);
      void'(exp_q.pop_front());
    end
    check("latency", 32'(cycles), exp_hit ? 32'd1 : 32'(lat + 1));
    check("bus_requested", {31'd0, saw_req}, {31'd0, !exp_hit});
    $display("fetch pc=0x%08h rdata=0x%08h cycles=%0d req=%0d hits=%0d misses=%0d",
             pc, got, cycles, saw_req, o_hit, o_miss);
  endtask

  // Counts FLUSH cycles from the next falling edge; also counts illegal fetch activity.
  task automatic count_flush(output int n, output int bad);
    n   = 0;
    bad = 0;
    for (int k = 0; k < 1000; k++) begin
      @(negedge i_clock);
      if (o_ready || o_bus_request) bad++;
      if (!o_flush_busy) break;
      n++;
    end
  endtask

  initial begin
    int n_busy, n_bad, n_act;
    vecs[0]  = '{32'h0000_0100, 32'hDEAD_BEEF, 3, 1'b0, 32'hDEAD_BEEF, 32'd0, 32'd1};
    vecs[1]  = '{32'h0000_0100, 32'h0000_0000, 1, 1'b1, 32'hDEAD_BEEF, 32'd1, 32'd1};
    vecs[2]  = '{32'h0000_0500, 32'h1234_5678, 2, 1'b0, 32'h1234_5678, 32'd1, 32'd2};
    vecs[3]  = '{32'h0000_0100, 32'hCAFE_F00D, 1, 1'b0, 32'hCAFE_F00D, 32'd1, 32'd3};
    vecs[4]  = '{32'h0000_0100, 32'h0000_0000, 1, 1'b1, 32'hCAFE_F00D, 32'd2, 32'd3};
    vecs[5]  = '{32'h0000_0504, 32'h0BAD_C0DE, 2, 1'b0, 32'h0BAD_C0DE, 32'd2, 32'd4};
    vecs[6]  = '{32'h0000_0500, 32'h1111_2222, 1, 1'b0, 32'h1111_2222, 32'd2, 32'd5};
    vecs[7]  = '{32'h0000_0504, 32'h0000_0000, 1, 1'b1, 32'h0BAD_C0DE, 32'd3, 32'd5};
    vecs[8]  = '{32'h0000_0500, 32'h0000_0000, 1, 1'b1, 32'h1111_2222, 32'd4, 32'd5};
    vecs[9]  = '{32'h0000_03FC, 32'hFFFF_0000, 3, 1'b0, 32'hFFFF_0000, 32'd4, 32'd6};
    vecs[10] = '{32'h0000_03FC, 32'h0000_0000, 1, 1'b1, 32'hFFFF_0000, 32'd5, 32'd6};
    vecs[11] = '{32'h0000_0000, 32'hA5A5_A5A5, 1, 1'b0, 32'hA5A5_A5A5, 32'd5, 32'd7};
    vecs[12] = '{32'h0000_0000, 32'h0000_0000, 1, 1'b1, 32'hA5A5_A5A5, 32'd6, 32'd7};
    vecs[13] = '{32'hFFFF_FFFC, 32'h7654_3210, 2, 1'b0, 32'h7654_3210, 32'd6, 32'd8};
    vecs[14] = '{32'h0000_03FC, 32'h1357_9BDF, 1, 1'b0, 32'h1357_9BDF, 32'd6, 32'd9};

    i_reset     = 1'b0;
    i_input_pc  = 32'h1234_5677;
    i_stall     = 1'b1;
    i_flush     = 1'b0;
    i_bus_ready = 1'b0;
    i_bus_rdata = '0;

    // Reset state
    repeat (3) @(posedge i_clock);
    @(negedge i_clock);
    check("rst_flush_busy", {31'd0, o_flush_busy}, 32'd1);
    check("rst_ready", {31'd0, o_ready}, 32'd0);
    check("rst_rdata", o_rdata, 32'd0);
    check("rst_bus_request", {31'd0, o_bus_request}, 32'd0);
    check("rst_bus_address", o_bus_address, 32'h1234_5674);
    check("rst_hit", o_hit, 32'd0);
    check("rst_miss", o_miss, 32'd0);

    // Release just after a rising edge; the sweep occupies the next 256 cycles.
    @(posedge i_clock);
    #1 i_reset = 1'b1;
    count_flush(n_busy, n_bad);
    check("init_sweep_cycles", 32'(n_busy), 32'd256);
    check("init_sweep_activity", 32'(n_bad), 32'd0);
    $display("init sweep busy=%0d cycles", n_busy);

    for (int i = 0; i < 15; i++) begin
      do_fetch(vecs[i].pc, vecs[i].bus_data, vecs[i].lat, vecs[i].exp_hit, vecs[i].exp_rdata, 0);
      check("hit_count", o_hit, vecs[i].exp_hits);
      check("miss_count", o_miss, vecs[i].exp_misses);
    end

    // Stall held for 10 IDLE cycles: nothing accepted.
    @(negedge i_clock);
    i_input_pc = 32'h0000_0700;
    n_act = 0;
    repeat (10) begin
      @(negedge i_clock);
      if (o_ready || o_bus_request) n_act++;
    end
    check("stall_activity", 32'(n_act), 32'd0);
    check("stall_hit", o_hit, 32'd6);
    check("stall_miss", o_miss, 32'd9);
    $display("stall 10 cycles activity=%0d", n_act);

    // Flush pulsed during FILL: fill completes, then a full sweep.
    do_fetch(32'h0000_0200, 32'h2222_AAAA, 3, 1'b0, 32'h2222_AAAA, 2);
    count_flush(n_busy, n_bad);
    check("fill_flush_cycles", 32'(n_busy), 32'd256);
    check("fill_flush_activity", 32'(n_bad), 32'd0);
    $display("flush after fill busy=%0d cycles", n_busy);
    do_fetch(32'h0000_0200, 32'h3333_BBBB, 1, 1'b0, 32'h3333_BBBB, 0);
    do_fetch(32'h0000_0100, 32'h4444_8888, 1, 1'b0, 32'h4444_8888, 0);
    do_fetch(32'h0000_0100, 32'h0000_0000, 1, 1'b1, 32'h4444_8888, 0);
    check("post_flush_hit", o_hit, 32'd7);
    check("post_flush_miss", o_miss, 32'd12);

    // Reset asserted mid-FILL.
    @(negedge i_clock);
    i_input_pc = 32'h0000_0600;
    i_stall    = 1'b0;
    @(posedge i_clock);
    #1 i_stall = 1'b1;
    @(negedge i_clock);
    check("lookup_request", {31'd0, o_bus_request}, 32'd1);
    @(negedge i_clock);
    check("fill_request", {31'd0, o_bus_request}, 32'd1);
    i_reset = 1'b0;
    #1;
    check("rst_fill_request", {31'd0, o_bus_request}, 32'd0);
    check("rst_fill_ready", {31'd0, o_ready}, 32'd0);
    check("rst_fill_hit", o_hit, 32'd0);
    check("rst_fill_miss", o_miss, 32'd0);
    check("rst_fill_busy", {31'd0, o_flush_busy}, 32'd1);
    $display("reset mid-fill request=%0d hits=%0d misses=%0d", o_bus_request, o_hit, o_miss);
    @(posedge i_clock);
    #1 i_reset = 1'b1;
    count_flush(n_busy, n_bad);
    check("rst_sweep_cycles", 32'(n_busy), 32'd256);
    do_fetch(32'h0000_0600, 32'h6666_0600, 1, 1'b0, 32'h6666_0600, 0);
    check("after_rst_miss", o_miss, 32'd1);

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish required finish");
    $fatal(1, "watchdog");
  end

endmodule
